// File: rtl/pc_fetch_unit.sv
// PC register plus instruction fetch over a valid/ready request and response handshake.
// A fetch takes at least two cycles (REQ, WAIT). The instruction is then held until the core advances.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int          IMEM_LAT_MAX = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] NextPC,
  input  logic        Advance,
  output logic [63:0] CurrentPC,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  output logic        IMemReqValid,
  input  logic        IMemReqReady,
  output logic [63:0] IMemReqAddr,
  input  logic        IMemRespValid,
  input  logic [31:0] IMemRespData,
  output logic        Fault,
  output logic [63:0] RetiredCount
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] LAT_MAX = 8'(IMEM_LAT_MAX);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_inc;
  logic        req_fire;
  logic        timed_out;
  logic        pc_misaligned;

  assign req_fire      = IMemReqValid && IMemReqReady;
  assign wait_cnt_inc  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  assign timed_out     = !IMemRespValid && (wait_cnt_inc >= LAT_MAX);
  assign pc_misaligned = (NextPC[1:0] != 2'b00);

  always_ff @(posedge CLK) begin
    if (Reset) state <= S_REQ;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_REQ:   if (req_fire) state_next = S_WAIT;
      S_WAIT: begin
        if (IMemRespValid)  state_next = S_HOLD;
        else if (timed_out) state_next = S_FAULT;
      end
      S_HOLD:  if (Advance) state_next = pc_misaligned ? S_FAULT : S_REQ;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
  end

  // Handshake outputs are pure state decode, so no input reaches an output combinationally.
  always_comb begin
    IMemReqValid = (state == S_REQ);
    IMemReqAddr  = (state == S_REQ) ? CurrentPC : 64'h0;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      CurrentPC    <= RESET_PC;
      Instruction  <= 32'h0;
      InstrValid   <= 1'b0;
      Fault        <= 1'b0;
      RetiredCount <= 64'h0;
      wait_cnt     <= 8'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) wait_cnt <= 8'h0;
        end
        S_WAIT: begin
          if (IMemRespValid) begin
            Instruction <= IMemRespData;
            InstrValid  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (timed_out) Fault <= 1'b1;
          end
        end
        S_HOLD: begin
          // A misaligned target is still committed so it can be inspected after the fault.
          if (Advance) begin
            CurrentPC    <= NextPC;
            InstrValid   <= 1'b0;
            RetiredCount <= RetiredCount + 64'd1;
            if (pc_misaligned) Fault <= 1'b1;
          end
        end
        default: begin
          InstrValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the architectural PC register and fetches the instruction at that PC from instruction memory over a valid/ready request and response handshake.
- Presents the fetched instruction to decode and exports CurrentPC to the next-PC adder/branch logic.
- When the core signals that the current instruction has completed, commits the NextPC value computed by that logic.
- Sits between instruction memory and the decode/next-PC datapath in the single-cycle processor.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset; bits [1:0] must be 0.
- IMEM_LAT_MAX, 15, maximum cycles WAIT may last before Fault is raised (timeout); range 1-255.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- NextPC  input  64  next PC from the branch/next-PC logic; sampled only on an accepted Advance.
- Advance  input  1  the core has completed the instruction at CurrentPC; commit NextPC.
- CurrentPC  output  64  registered PC of the instruction being fetched or held.
- Instruction  output  32  latched fetched instruction; valid only while InstrValid=1.
- InstrValid  output  1  Instruction corresponds to CurrentPC.
- IMemReqValid  output  1  fetch request is valid.
- IMemReqReady  input  1  memory accepts the request this cycle.
- IMemReqAddr  output  64  equals CurrentPC whenever IMemReqValid=1.
- IMemRespValid  input  1  response data is valid.
- IMemRespData  input  32  instruction word.
- Fault  output  1  sticky error: misaligned PC or memory timeout.
- RetiredCount  output  64  number of accepted Advance events since reset.

Behaviour:
- Reset values, effective at the edge where Reset=1:
  - state=REQ; CurrentPC=RESET_PC; Instruction=32'h0; InstrValid=0.
  - Fault=0; RetiredCount=0; timeout counter=0.
  - Reset has priority over every other input. Reset in any state abandons the fetch in progress.
  - Instruction memory shares Reset, so no stale response arrives after reset.
- States:
  - REQ: IMemReqValid=1, IMemReqAddr=CurrentPC.
    - On IMemReqValid and IMemReqReady both 1 at an edge -> WAIT, timeout counter=0.
    - Otherwise hold; the request is kept stable until accepted.
  - WAIT: IMemReqValid=0; timeout counter increments each cycle.
    - On IMemRespValid=1: Instruction<=IMemRespData, InstrValid<=1 -> HOLD.
    - If the counter reaches IMEM_LAT_MAX with no response: Fault<=1 -> FAULT.
    - The response is taken in WAIT only. A response in the same cycle the request is accepted (REQ) is ignored, so minimum fetch latency is request edge + 1 cycle.
  - HOLD: InstrValid=1; Instruction and CurrentPC stable.
    - On Advance=1: CurrentPC<=NextPC, InstrValid<=0, RetiredCount<=RetiredCount+1 (wraps modulo 2^64).
    - If NextPC[1:0]==0 -> REQ; else Fault<=1 -> FAULT. CurrentPC still takes the misaligned value so it is visible for debug.
  - FAULT: all handshake outputs 0; InstrValid=0; Advance ignored; exit only by Reset.
- Advance is ignored in REQ, WAIT and FAULT; RetiredCount does not change.
- IMemRespValid is ignored outside WAIT.
- Throughput: with a 1-cycle memory, one instruction per 3 cycles (REQ, WAIT, HOLD with Advance).
- Arithmetic: the timeout counter is 8 bits and saturates. PC arithmetic is not done here; NextPC is taken verbatim.
- All outputs are driven directly from registers or from state decode; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset with RESET_PC=0; memory ready=1 and responds 1 cycle later with 32'hF8000001 -> IMemReqAddr=0 for one cycle; InstrValid=1 two cycles after reset release; Instruction=32'hF8000001.
2. In HOLD, Advance=1 with NextPC=0x4, then again with NextPC=0x40 (taken branch) -> next requests at 0x4 then 0x40; RetiredCount=2; CurrentPC=0x40.
3. IMemReqReady low for 3 cycles in REQ -> IMemReqValid held at 1 with a stable address for 4 cycles; no state advance.
4. Advance with NextPC=0x6 -> CurrentPC=0x6; Fault=1 from the next cycle; no further requests; Advance pulses ignored; RetiredCount frozen at 1.
5. IMEM_LAT_MAX=3 and no response -> Fault=1 after 3 WAIT cycles; IMemRespValid arriving later is ignored.
6. Reset asserted in WAIT, then released -> CurrentPC=RESET_PC, Fault=0, RetiredCount=0; a new request is issued the cycle after release.
